// File: rtl/fft_pkg.sv
// Shared FFT/IFFT definitions.
//   WIDTH     : default signed sample width of complex ports
//   sample_t  : one signed real or imaginary sample
//   cplx_t    : packed complex sample {re, im}
//   sat_half  : (v + rnd) >>> 1, clamped to a signed w-bit range
//   sat_half_ovf : flags whether sat_half clamped its result
// The helpers work on 32-bit signed carriers so that stages with any sample
// width up to 29 bits can share them; callers truncate the result to w bits.
package fft_pkg;

    localparam int unsigned WIDTH = 16;

    typedef logic signed [WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_t;

    // Halve with optional round-half-up, then clamp to [-2**(w-1), 2**(w-1)-1].
    function automatic logic signed [31:0] sat_half(
        input logic signed [31:0] v,
        input logic               rnd,
        input int unsigned        w
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r  = (v + $signed({31'b0, rnd})) >>> 1;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

    function automatic logic sat_half_ovf(
        input logic signed [31:0] v,
        input logic               rnd,
        input int unsigned        w
    );
        logic signed [31:0] r;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        r  = (v + $signed({31'b0, rnd})) >>> 1;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        return (r > hi) || (r < lo);
    endfunction

endpackage

// File: rtl/bfly_pipe_reg.sv
// Generic valid/ready register slice (one pipeline stage).
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake; in_ready is combinational
//                         from out_ready so a full slice still streams
//   in_data [DW-1:0]    : payload captured on an upstream transfer
//   out_valid/out_ready : downstream handshake
//   out_data [DW-1:0]   : registered payload, held while stalled
module bfly_pipe_reg #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);
    import fft_pkg::*;

    logic          valid_q;
    logic          valid_d;
    logic [DW-1:0] data_q;
    logic [DW-1:0] data_d;
    logic          load;

    always_comb begin
        // The slice may load whenever it is empty or its content leaves now.
        load    = !valid_q || out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = load;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/butterfly_inv.sv
// Streaming radix-2 inverse butterfly: recovers x1 = (sum - diff) / 2 and
// x2 = (sum + diff) / 2 from a forward butterfly pair.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready/in_last  : input handshake and end-of-frame marker
//   sum_re/im, diff_re/im      : signed WIDTH-bit complex inputs
//   out_valid/out_ready        : output handshake
//   out_last                   : in_last delayed with its pair
//   x1_re/im, x2_re/im         : recovered signed WIDTH-bit samples
//   out_idx                    : index of the presented pair within its frame
//   sat_flag                   : sticky, set when any output was clamped
// Stage 1 forms a = sum - diff and b = sum + diff in WIDTH+2 bits; stage 2
// halves (floor or round-half-up per ROUND) and saturates to WIDTH bits.
module butterfly_inv #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ROUND = 0,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] sum_re,
    input  logic [WIDTH-1:0] sum_im,
    input  logic [WIDTH-1:0] diff_re,
    input  logic [WIDTH-1:0] diff_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [WIDTH-1:0] x1_re,
    output logic [WIDTH-1:0] x1_im,
    output logic [WIDTH-1:0] x2_re,
    output logic [WIDTH-1:0] x2_im,
    output logic [IDX_W-1:0] out_idx,
    output logic             sat_flag
);
    import fft_pkg::*;

    localparam int unsigned EW   = WIDTH + 2;
    localparam int unsigned S1_W = 1 + 4 * EW;
    localparam int unsigned S2_W = 1 + 4 * WIDTH;
    localparam logic        RND  = (ROUND != 0);

    // Stage 1 datapath
    logic signed [EW-1:0] sum_re_x;
    logic signed [EW-1:0] sum_im_x;
    logic signed [EW-1:0] diff_re_x;
    logic signed [EW-1:0] diff_im_x;
    logic signed [EW-1:0] a_re;
    logic signed [EW-1:0] a_im;
    logic signed [EW-1:0] b_re;
    logic signed [EW-1:0] b_im;
    logic [S1_W-1:0]      s1_in;
    logic [S1_W-1:0]      s1_out;
    logic                 s1_valid;
    logic                 s2_ready;

    // Stage 2 datapath
    logic                 s1_last;
    logic signed [EW-1:0] a_re_q;
    logic signed [EW-1:0] a_im_q;
    logic signed [EW-1:0] b_re_q;
    logic signed [EW-1:0] b_im_q;
    logic [WIDTH-1:0]     x1_re_s;
    logic [WIDTH-1:0]     x1_im_s;
    logic [WIDTH-1:0]     x2_re_s;
    logic [WIDTH-1:0]     x2_im_s;
    logic                 sat_any;
    logic [S2_W-1:0]      s2_in;
    logic [S2_W-1:0]      s2_out;

    // Control state
    logic                 sat_flag_q;
    logic                 sat_flag_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic                 out_hs;

    always_comb begin
        sum_re_x  = {{2{sum_re[WIDTH-1]}}, sum_re};
        sum_im_x  = {{2{sum_im[WIDTH-1]}}, sum_im};
        diff_re_x = {{2{diff_re[WIDTH-1]}}, diff_re};
        diff_im_x = {{2{diff_im[WIDTH-1]}}, diff_im};
        a_re      = sum_re_x - diff_re_x;
        a_im      = sum_im_x - diff_im_x;
        b_re      = sum_re_x + diff_re_x;
        b_im      = sum_im_x + diff_im_x;
        s1_in     = {in_last, a_re, a_im, b_re, b_im};
    end

    bfly_pipe_reg #(
        .DW(S1_W)
    ) u_s1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (s1_in),
        .out_valid(s1_valid),
        .out_ready(s2_ready),
        .out_data (s1_out)
    );

    always_comb begin
        s1_last = s1_out[S1_W-1];
        a_re_q  = $signed(s1_out[4*EW-1 -: EW]);
        a_im_q  = $signed(s1_out[3*EW-1 -: EW]);
        b_re_q  = $signed(s1_out[2*EW-1 -: EW]);
        b_im_q  = $signed(s1_out[EW-1:0]);

        x1_re_s = WIDTH'(sat_half(32'(a_re_q), RND, WIDTH));
        x1_im_s = WIDTH'(sat_half(32'(a_im_q), RND, WIDTH));
        x2_re_s = WIDTH'(sat_half(32'(b_re_q), RND, WIDTH));
        x2_im_s = WIDTH'(sat_half(32'(b_im_q), RND, WIDTH));

        sat_any = sat_half_ovf(32'(a_re_q), RND, WIDTH)
                | sat_half_ovf(32'(a_im_q), RND, WIDTH)
                | sat_half_ovf(32'(b_re_q), RND, WIDTH)
                | sat_half_ovf(32'(b_im_q), RND, WIDTH);

        s2_in = {s1_last, x1_re_s, x1_im_s, x2_re_s, x2_im_s};
    end

    bfly_pipe_reg #(
        .DW(S2_W)
    ) u_s2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_ready (s2_ready),
        .in_data  (s2_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (s2_out)
    );

    assign out_last = s2_out[S2_W-1];
    assign x1_re    = s2_out[4*WIDTH-1 -: WIDTH];
    assign x1_im    = s2_out[3*WIDTH-1 -: WIDTH];
    assign x2_re    = s2_out[2*WIDTH-1 -: WIDTH];
    assign x2_im    = s2_out[WIDTH-1:0];

    always_comb begin
        out_hs = out_valid && out_ready;
        // Only a real pair moving into S2 can raise the flag.
        sat_flag_d = sat_flag_q | (s2_ready & s1_valid & sat_any);
        idx_d      = idx_q;
        // idx_q always names the pair currently held in S2; it advances when
        // that pair leaves and restarts at a frame end or on wrap.
        if (out_hs) begin
            if (out_last || (idx_q == '1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            sat_flag_q <= sat_flag_d;
            idx_q      <= idx_d;
        end
    end

    assign sat_flag = sat_flag_q;
    assign out_idx  = idx_q;

endmodule

// File: tb/tb_butterfly_inv.sv
// Self-checking bench for butterfly_inv. Two instances share all inputs:
// dut0 uses floor halving, dut1 uses round-half-up.
module tb_butterfly_inv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [15:0] sum_re, sum_im, diff_re, diff_im;

    logic        in_ready0, out_valid0, out_last0, sat0;
    logic [15:0] x1_re0, x1_im0, x2_re0, x2_im0;
    logic [3:0]  idx0;
    logic        in_ready1, out_valid1, out_last1, sat1;
    logic [15:0] x1_re1, x1_im1, x2_re1, x2_im1;
    logic [3:0]  idx1;

    int checks = 0;
    int errors = 0;

    butterfly_inv #(.WIDTH(16), .ROUND(0), .IDX_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_last(in_last), .sum_re(sum_re), .sum_im(sum_im),
        .diff_re(diff_re), .diff_im(diff_im), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .x1_re(x1_re0),
        .x1_im(x1_im0), .x2_re(x2_re0), .x2_im(x2_im0), .out_idx(idx0),
        .sat_flag(sat0)
    );

    butterfly_inv #(.WIDTH(16), .ROUND(1), .IDX_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_last(in_last), .sum_re(sum_re), .sum_im(sum_im),
        .diff_re(diff_re), .diff_im(diff_im), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .x1_re(x1_re1),
        .x1_im(x1_im1), .x2_re(x2_re1), .x2_im(x2_im1), .out_idx(idx1),
        .sat_flag(sat1)
    );

    typedef struct {
        int s_re, s_im, d_re, d_im;
        int f_x1re, f_x1im, f_x2re, f_x2im;
        int r_x1re, r_x1im, r_x2re, r_x2im;
        int sat_r;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int sr, input int si, input int dr, input int di);
        sum_re  = 16'(sr);
        sum_im  = 16'(si);
        diff_re = 16'(dr);
        diff_im = 16'(di);
    endtask

    // Reference halving: floor (r=0) or round-half-up (r=1).
    function automatic int half(input int v, input int r);
        return (v + r) >>> 1;
    endfunction

    function automatic int p_sr(input int k); return k * 37 - 200; endfunction
    function automatic int p_si(input int k); return 500 - k * 11; endfunction
    function automatic int p_dr(input int k); return k * 5 - 30;   endfunction
    function automatic int p_di(input int k); return k * 3 + 7;    endfunction

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_pair(input string tag, input int k);
        int sr, si, dr, di;
        sr = p_sr(k); si = p_si(k); dr = p_dr(k); di = p_di(k);
        chk({tag, " x1_re floor"}, $signed(x1_re0), half(sr - dr, 0));
        chk({tag, " x1_im floor"}, $signed(x1_im0), half(si - di, 0));
        chk({tag, " x2_re floor"}, $signed(x2_re0), half(sr + dr, 0));
        chk({tag, " x2_im floor"}, $signed(x2_im0), half(si + di, 0));
        chk({tag, " x1_re round"}, $signed(x1_re1), half(sr - dr, 1));
        chk({tag, " x1_im round"}, $signed(x1_im1), half(si - di, 1));
        chk({tag, " x2_re round"}, $signed(x2_re1), half(sr + dr, 1));
        chk({tag, " x2_im round"}, $signed(x2_im1), half(si + di, 1));
    endtask

    // Per-cycle streaming with a handshake-count scoreboard. Output order
    // equals input order, so the k-th output is compared against pair k.
    task automatic run_stream(input string tag, input int n, input int last_pos,
                              input int st_lo, input int st_hi, input bit bubbles);
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        int          base;
        bit          prev_stall = 1'b0;
        logic [63:0] snap = '0;
        logic [4:0]  snap_ctl = '0;
        while (got < n && cyc < 300) begin
            @(negedge clk);
            out_ready = !(cyc >= st_lo && cyc <= st_hi);
            if (bubbles && (cyc % 5 == 4)) out_ready = 1'b0;
            if (sent < n && !(bubbles && (cyc % 3 == 2))) begin
                drive(p_sr(sent), p_si(sent), p_dr(sent), p_di(sent));
                in_valid = 1'b1;
                in_last  = (sent == last_pos);
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            #1;
            chk({tag, " in_ready"}, in_ready0, ((sent - got) < 2) || out_ready);
            chk({tag, " in_ready rnd"}, in_ready1, ((sent - got) < 2) || out_ready);
            if (prev_stall) begin
                chk({tag, " stall hold data"}, longint'({x1_re0, x1_im0, x2_re0, x2_im0}),
                    longint'(snap));
                chk({tag, " stall hold ctl"}, {out_last0, idx0}, snap_ctl);
            end
            if (out_valid0 && out_ready) begin
                base = (last_pos >= 0 && got > last_pos) ? got - last_pos - 1 : got;
                chk_pair(tag, got);
                chk({tag, " out_idx"}, idx0, base % 16);
                chk({tag, " out_last"}, out_last0, got == last_pos);
                chk({tag, " out_valid rnd"}, out_valid1, 1);
                got++;
            end
            prev_stall = out_valid0 && !out_ready;
            if (prev_stall) begin
                snap     = {x1_re0, x1_im0, x2_re0, x2_im0};
                snap_ctl = {out_last0, idx0};
            end
            if (in_valid && in_ready0) sent++;
            cyc++;
        end
        chk({tag, " outputs received"}, got, n);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run not complete at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0] = '{300, -40, 100, 20,       100, -30, 200, -10,     100, -30, 200, -10,     0};
        tv[1] = '{5, -5, 2, 0,             1, -3, 3, -3,           2, -2, 4, -2,           0};
        tv[2] = '{-7, 0, -3, 1,            -2, -1, -5, 0,          -2, 0, -5, 1,           0};
        tv[3] = '{32767, -32768, 32767, -32768, 0, 0, 32767, -32768, 0, 0, 32767, -32768, 0};
        tv[4] = '{32767, -32768, -32768, 32767, 32767, -32768, -1, -1, 32767, -32767, 0, 0, 1};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", out_valid0, 0);
        chk("reset in_ready", in_ready0, 1);
        chk("reset out_idx", idx0, 0);
        chk("reset sat_flag", sat1, 0);
        chk("reset x1_re", x1_re0, 0);
        chk("reset out_last", out_last0, 0);

        // Single pairs through an idle pipe.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(tv[i].s_re, tv[i].s_im, tv[i].d_re, tv[i].d_im);
            in_valid = 1'b1;
            in_last  = 1'b0;
            @(posedge clk);
            #1 in_valid = 1'b0;
            chk($sformatf("vec%0d out_valid after 1 edge", i), out_valid0, 0);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out_valid", i), out_valid0, 1);
            chk($sformatf("vec%0d out_valid rnd", i), out_valid1, 1);
            chk($sformatf("vec%0d x1_re floor", i), $signed(x1_re0), tv[i].f_x1re);
            chk($sformatf("vec%0d x1_im floor", i), $signed(x1_im0), tv[i].f_x1im);
            chk($sformatf("vec%0d x2_re floor", i), $signed(x2_re0), tv[i].f_x2re);
            chk($sformatf("vec%0d x2_im floor", i), $signed(x2_im0), tv[i].f_x2im);
            chk($sformatf("vec%0d x1_re round", i), $signed(x1_re1), tv[i].r_x1re);
            chk($sformatf("vec%0d x1_im round", i), $signed(x1_im1), tv[i].r_x1im);
            chk($sformatf("vec%0d x2_re round", i), $signed(x2_re1), tv[i].r_x2re);
            chk($sformatf("vec%0d x2_im round", i), $signed(x2_im1), tv[i].r_x2im);
            chk($sformatf("vec%0d out_idx", i), idx0, i);
            chk($sformatf("vec%0d out_last", i), out_last0, 0);
            chk($sformatf("vec%0d sat_flag floor", i), sat0, 0);
            chk($sformatf("vec%0d sat_flag round", i), sat1, tv[i].sat_r);
        end

        // Asynchronous reset with two pairs in flight.
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(p_sr(0), p_si(0), p_dr(0), p_di(0));
        in_valid = 1'b1;
        @(negedge clk);
        drive(p_sr(1), p_si(1), p_dr(1), p_di(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("prereset out_valid", out_valid0, 1);
        chk("prereset in_ready", in_ready0, 0);
        chk("prereset out_idx", idx0, 5);
        chk("prereset sat_flag", sat1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset out_valid", out_valid0, 0);
        chk("midreset out_valid rnd", out_valid1, 0);
        chk("midreset out_idx", idx0, 0);
        chk("midreset sat_flag", sat1, 0);
        chk("midreset in_ready", in_ready0, 1);
        chk("midreset x1_re", x1_re0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        drive(p_sr(3), p_si(3), p_dr(3), p_di(3));
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("postreset out_valid early", out_valid0, 0);
        @(posedge clk);
        #1;
        chk("postreset out_valid", out_valid0, 1);
        chk_pair("postreset", 3);
        chk("postreset out_idx", idx0, 0);
        @(negedge clk);

        apply_reset();
        run_stream("bp", 8, -1, 3, 7, 1'b0);
        apply_reset();
        run_stream("frame", 20, 5, -1, -1, 1'b1);
        apply_reset();
        run_stream("wrap", 18, -1, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_inv.md
Name: butterfly_inv

Overview:
Streaming radix-2 inverse butterfly. It undoes the forward butterfly pair relation (sum = x1 + x2, diff = x2 - x1) and recovers x1 and x2 in 16-bit signed complex form.
It sits on the IFFT/verification return path, after a forward butterfly stage or a stage memory, and uses a valid/ready handshake.
It is a two-stage pipeline with full backpressure, optional rounding, output saturation, and an in-frame sample index.

Parameters:
WIDTH, 16, signed sample width of every real/imag port
ROUND, 0, 0 = floor (arithmetic shift); 1 = round-half-up before the halving shift
IDX_W, 4, width of out_idx; frame length is 2**IDX_W pairs

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input pair valid
in_ready  output  1  block can accept input this cycle
in_last  input  1  last pair of frame, travels with data
sum_re  input  WIDTH  signed real part of x1+x2
sum_im  input  WIDTH  signed imag part of x1+x2
diff_re  input  WIDTH  signed real part of x2-x1
diff_im  input  WIDTH  signed imag part of x2-x1
out_valid  output  1  output pair valid
out_ready  input  1  downstream accepts
out_last  output  1  delayed in_last
x1_re, x1_im, x2_re, x2_im  output  WIDTH  recovered samples, signed
out_idx  output  IDX_W  index of current output pair within frame
sat_flag  output  1  sticky: any output saturated since reset

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-transfer) clears all pipeline valids, all data/out_last/out_idx registers to 0, and sat_flag to 0. in_ready reads 1 once the valids are 0.
- Handshake: a transfer occurs when valid and ready are both high on a clock edge. out_* are held stable while out_valid=1 and out_ready=0.
- Stage 1 (S1): registers a = sum - diff and b = sum + diff per component, each sign-extended to WIDTH+2 bits, plus last.
- Stage 2 (S2): computes r = (v + ROUND) >>> 1 in WIDTH+2 bits. It then saturates to [-2**(WIDTH-1), 2**(WIDTH-1)-1] and registers x1 = sat(a), x2 = sat(b).
- Any saturation at the S2 register load sets sat_flag.
- Latency: 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 pair/cycle.
- Stage advance: S2 loads when !s2_valid || out_ready. S1 loads when !s1_valid || S2 loads. in_ready = !s1_valid || S2 loads (combinational from out_ready; no bubble on sustained flow).
- Simultaneous in/out handshake on a full pipe: both occur, with no loss or duplication.
- out_idx: counter, 0 after reset. It increments on each output handshake. It returns to 0 after an output handshake with out_last=1, or after wrapping from 2**IDX_W-1, whichever comes first. It is registered alongside the S2 data.
- in_valid deasserting mid-frame creates bubbles only. out_idx counts handshakes, not cycles.

Decomposition:
- fft_pkg: WIDTH constant, sample_t (logic signed [WIDTH-1:0]), cplx_t struct {re, im}, and function sat_half(v, round) shared with future IFFT stages.
- One sub-module: bfly_pipe_reg, a generic valid/ready register slice instantiated for S1 and S2.
- The arithmetic stays in the top module.

Test Plan:
- sum=(300,-40), diff=(100,20), ROUND=0, out_ready=1 -> after 2 cycles x1=(100,-30), x2=(200,-10), out_idx=0.
- Odd/negative rounding: sum_re=5, diff_re=2 -> ROUND=0: x1_re=1, x2_re=3; ROUND=1: x1_re=2, x2_re=4. Also sum_re=-5, diff_re=0 -> x1_re=x2_re=-3 (ROUND=0) or -2 (ROUND=1).
- Saturation: sum_re=32767, diff_re=-32768, ROUND=1 -> x1_re=32767 (saturated), x2_re=0, sat_flag=1. With ROUND=0: x1_re=32767, x2_re=-1, sat_flag stays 0.
- Backpressure: stream 8 pairs, hold out_ready=0 for cycles 3-7 -> in_ready drops after 2 pairs buffered; outputs are stable, in order, none lost.
- Frame index: 20 pairs with in_last on pair 5, IDX_W=4 -> out_idx runs 0..5, then 0..13, with out_last only on the 6th output.
- Reset mid-stream: assert rst_n low while 2 pairs are in flight -> out_valid=0, out_idx=0, sat_flag=0 immediately. After release, the first new pair is output 2 cycles after its input handshake.
